// File: rtl/ram_seq_ctrl.sv
// ram_seq_ctrl: FILL/SCAN sweep sequencer for a single-port RAM (2**ADDR_W x DATA_W).
// Build option RAM_SEQ_PATTERN_EN: FILL writes fill_data + address instead of a constant.
`default_nettype none

module ram_seq_ctrl #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 4,
    parameter int DWELL  = 25_000_000,
    parameter int RD_LAT = 1
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              mode_i,
    input  logic [DATA_W-1:0] fill_data_i,
    input  logic              abort_i,
    input  logic [DATA_W-1:0] q_i,
    output logic [ADDR_W-1:0] address_o,
    output logic [DATA_W-1:0] data_o,
    output logic              wren_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic              rd_valid_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int                DW_W       = $clog2(DWELL + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = {ADDR_W{1'b1}};
    localparam logic [DW_W-1:0]   DWELL_LAST = DW_W'(DWELL - 1);
    localparam logic [DW_W-1:0]   RD_CAPTURE = DW_W'(RD_LAT);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_FILL       = 3'd1,
        S_SCAN_ISSUE = 3'd2,
        S_SCAN_WAIT  = 3'd3,
        S_SCAN_HOLD  = 3'd4,
        S_DONE       = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DW_W-1:0]   dwell_q, dwell_d;
    logic [DATA_W-1:0] fill_q, fill_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              rd_valid_q, rd_valid_d;
    logic              active;
    logic [DATA_W-1:0] pattern;

`ifdef RAM_SEQ_PATTERN_EN
    assign pattern = fill_q + DATA_W'(cnt_q);
`else
    assign pattern = fill_q;
`endif

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            dwell_q    <= '0;
            fill_q     <= '0;
            rd_data_q  <= '0;
            rd_addr_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dwell_q    <= dwell_d;
            fill_q     <= fill_d;
            rd_data_q  <= rd_data_d;
            rd_addr_q  <= rd_addr_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dwell_d    = dwell_q;
        fill_d     = fill_q;
        rd_data_d  = rd_data_q;
        rd_addr_d  = rd_addr_q;
        rd_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    fill_d  = fill_data_i;
                    cnt_d   = '0;
                    dwell_d = '0;
                    state_d = mode_i ? S_SCAN_ISSUE : S_FILL;
                end
            end
            S_FILL: begin
                if (cnt_q == LAST_ADDR) state_d = S_DONE;
                else                    cnt_d   = cnt_q + 1'b1;
            end
            S_SCAN_ISSUE: begin
                dwell_d = dwell_q + 1'b1;
                state_d = S_SCAN_WAIT;
            end
            S_SCAN_WAIT: begin
                // dwell_q counts cycles since the address was issued, so it doubles as the read-latency timer
                dwell_d = dwell_q + 1'b1;
                if (dwell_q == RD_CAPTURE) begin
                    rd_data_d  = q_i;
                    rd_addr_d  = cnt_q;
                    rd_valid_d = 1'b1;
                    state_d    = S_SCAN_HOLD;
                end
            end
            S_SCAN_HOLD: begin
                if (dwell_q >= DWELL_LAST) begin
                    dwell_d = '0;
                    if (cnt_q == LAST_ADDR) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = S_SCAN_ISSUE;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            S_DONE: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (abort_i) begin
            state_d    = S_IDLE;
            cnt_d      = '0;
            dwell_d    = '0;
            fill_d     = fill_q;
            rd_data_d  = rd_data_q;
            rd_addr_d  = rd_addr_q;
            rd_valid_d = 1'b0;
        end
    end

    always_comb begin
        active     = (state_q == S_FILL) || (state_q == S_SCAN_ISSUE) ||
                     (state_q == S_SCAN_WAIT) || (state_q == S_SCAN_HOLD);
        address_o  = active ? cnt_q : '0;
        data_o     = (state_q == S_FILL) ? pattern : '0;
        wren_o     = (state_q == S_FILL) && !abort_i;
        busy_o     = active;
        done_o     = (state_q == S_DONE);
        rd_data_o  = rd_data_q;
        rd_addr_o  = rd_addr_q;
        rd_valid_o = rd_valid_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_ram_seq_ctrl.sv
// tb_ram_seq_ctrl: drives ram_seq_ctrl against a behavioural 32x4 RAM and a golden memory image.
`default_nettype none

module tb_ram_seq_ctrl;

    localparam int DWELL  = 4;
    localparam int RD_LAT = 1;
    localparam int DEPTH  = 32;
`ifdef RAM_SEQ_PATTERN_EN
    localparam bit PAT_EN = 1'b1;
`else
    localparam bit PAT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic [3:0] fill_data = 4'h0;
    logic       abort = 1'b0;
    logic [3:0] q = 4'h0;
    logic [4:0] address;
    logic [3:0] data;
    logic       wren;
    logic [3:0] rd_data;
    logic [4:0] rd_addr;
    logic       rd_valid;
    logic       busy;
    logic       done;

    logic [3:0] mem  [DEPTH];
    logic [3:0] gold [DEPTH];

    int tests_run = 0;
    int tests_failed = 0;

    ram_seq_ctrl #(.ADDR_W(5), .DATA_W(4), .DWELL(DWELL), .RD_LAT(RD_LAT)) dut (
        .clock_i     (clk),
        .reset_i     (reset),
        .start_i     (start),
        .mode_i      (mode),
        .fill_data_i (fill_data),
        .abort_i     (abort),
        .q_i         (q),
        .address_o   (address),
        .data_o      (data),
        .wren_o      (wren),
        .rd_data_o   (rd_data),
        .rd_addr_o   (rd_addr),
        .rd_valid_o  (rd_valid),
        .busy_o      (busy),
        .done_o      (done)
    );

    always #5 clk = ~clk;

    // Single-port RAM, registered read (one cycle of latency)
    always @(posedge clk) begin
        if (wren) mem[address] <= data;
        q <= mem[address];
    end

    function automatic logic [3:0] pat(input logic [3:0] fd, input int n);
        return PAT_EN ? 4'((int'(fd) + n) % 16) : fd;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_idle_outputs(input string name);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_wren"}, wren, 0);
        chk({name, "_addr"}, address, 0);
        chk({name, "_data"}, data, 0);
        chk({name, "_done"}, done, 0);
    endtask

    task automatic ram_cmp(input string name);
        int bad = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== gold[i]) bad++;
        chk(name, bad, 0);
    endtask

    // Enter at an IDLE negedge; leave at the IDLE negedge right after the sweep ends
    task automatic run_fill(input logic [3:0] fd, input int abort_at);
        start = 1'b1; mode = 1'b0; fill_data = fd;
        @(negedge clk);
        start = 1'b0; fill_data = ~fd;
        for (int n = 0; n < DEPTH; n++) begin
            if (n == abort_at) begin
                abort = 1'b1;
                #1;
                chk("abort_wren_forced_low", wren, 0);
                @(negedge clk);
                abort = 1'b0;
                chk("abort_busy_next", busy, 0);
                chk("abort_no_done", done, 0);
                @(negedge clk);
                chk("abort_no_done_later", done, 0);
                return;
            end
            chk("fill_wren", wren, 1);
            chk("fill_addr", address, n);
            chk("fill_data", data, pat(fd, n));
            chk("fill_busy", busy, 1);
            chk("fill_done_early", done, 0);
            gold[n] = pat(fd, n);
            @(negedge clk);
        end
        chk("fill_done", done, 1);
        chk("fill_done_busy", busy, 0);
        chk("fill_done_wren", wren, 0);
        chk("fill_done_addr", address, 0);
        @(negedge clk);
        chk("fill_done_one_cycle", done, 0);
    endtask

    // Slot c/DWELL issues address c/DWELL; its read result appears RD_LAT+1 cycles after issue
    task automatic run_scan(input int poke_at, input int reset_at);
        int a;
        bit v;
        int last_addr = 0;
        start = 1'b1; mode = 1'b1;
        @(negedge clk);
        start = 1'b0; mode = 1'b0;
        for (int c = 0; c < DEPTH * DWELL; c++) begin
            a = c / DWELL;
            v = ((c % DWELL) == RD_LAT + 1);
            chk("scan_busy", busy, 1);
            chk("scan_wren", wren, 0);
            chk("scan_addr", address, a);
            chk("scan_valid", rd_valid, v);
            chk("scan_done_early", done, 0);
            if (v) begin
                chk("scan_rd_addr", rd_addr, a);
                chk("scan_rd_data", rd_data, gold[a]);
                last_addr = a;
            end else if (c > RD_LAT + 1) begin
                chk("scan_rd_addr_stable", rd_addr, last_addr);
                chk("scan_rd_data_stable", rd_data, gold[last_addr]);
            end
            start = (c == poke_at);
            if (c == reset_at) begin
                @(posedge clk);
                #2 reset = 1'b1;
                #1;
                chk_idle_outputs("async_reset");
                chk("async_reset_rd_valid", rd_valid, 0);
                chk("async_reset_rd_addr", rd_addr, 0);
                chk("async_reset_rd_data", rd_data, 0);
                @(negedge clk);
                reset = 1'b0;
                chk_idle_outputs("after_reset");
                return;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("scan_done", done, 1);
        chk("scan_done_busy", busy, 0);
        chk("scan_done_rd_addr", rd_addr, DEPTH - 1);
        chk("scan_done_rd_data", rd_data, gold[DEPTH-1]);
        @(negedge clk);
        chk("scan_done_one_cycle", done, 0);
    endtask

    typedef struct {
        logic start;
        logic mode;
        logic abort;
        logic exp_busy;
        logic exp_wren;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{start: 1'b1, mode: 1'b0, abort: 1'b1, exp_busy: 1'b0, exp_wren: 1'b0};
        vecs[1] = '{start: 1'b1, mode: 1'b1, abort: 1'b1, exp_busy: 1'b0, exp_wren: 1'b0};
        vecs[2] = '{start: 1'b0, mode: 1'b0, abort: 1'b1, exp_busy: 1'b0, exp_wren: 1'b0};
        vecs[3] = '{start: 1'b0, mode: 1'b1, abort: 1'b0, exp_busy: 1'b0, exp_wren: 1'b0};
        vecs[4] = '{start: 1'b1, mode: 1'b0, abort: 1'b0, exp_busy: 1'b1, exp_wren: 1'b1};
        vecs[5] = '{start: 1'b1, mode: 1'b1, abort: 1'b0, exp_busy: 1'b1, exp_wren: 1'b0};
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]  = 4'h0;
            gold[i] = 4'h0;
        end

        repeat (2) @(negedge clk);
        chk_idle_outputs("reset");
        chk("reset_rd_valid", rd_valid, 0);
        chk("reset_rd_addr", rd_addr, 0);
        reset = 1'b0;
        @(negedge clk);
        chk_idle_outputs("post_reset");

        // One-cycle request from IDLE, then abort back to IDLE
        for (int i = 0; i < 6; i++) begin
            start = vecs[i].start; mode = vecs[i].mode; abort = vecs[i].abort; fill_data = 4'h3;
            @(negedge clk);
            start = 1'b0; abort = 1'b0;
            chk($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
            chk($sformatf("vec%0d_wren", i), wren, vecs[i].exp_wren);
            abort = 1'b1;
            #1;
            chk($sformatf("vec%0d_abort_wren", i), wren, 0);
            @(negedge clk);
            abort = 1'b0;
            chk($sformatf("vec%0d_idle_busy", i), busy, 0);
            chk($sformatf("vec%0d_no_done", i), done, 0);
        end
        ram_cmp("vec_ram_untouched");

        run_fill(4'hA, -1);
        ram_cmp("fill_A_ram");
        chk("fill_A_word6", mem[6], PAT_EN ? 0 : 4'hA);

        run_scan(37, -1);

        run_fill(4'h5, 10);
        ram_cmp("abort_fill_ram");
        chk("abort_fill_word10_kept", mem[10], pat(4'hA, 10));
        run_scan(-1, -1);

        run_fill(4'hC, -1);
        run_fill(4'h3, -1);
        ram_cmp("back_to_back_ram");

        for (int r = 0; r < 3; r++) begin
            logic [3:0] fd;
            fd = 4'($urandom_range(0, 15));
            run_fill(fd, int'($urandom_range(0, 40)));
            ram_cmp($sformatf("rand%0d_ram", r));
            run_scan(int'($urandom_range(0, 120)), -1);
        end

        run_scan(-1, 50);
        run_fill(4'h7, -1);
        ram_cmp("post_reset_fill_ram");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
